// File: rtl/alu_sys_pkg.sv
// Shared definitions for the ALU command subsystem: widths, command
// opcodes, the error byte and the controller state encoding.
package alu_sys_pkg;

  localparam int DATA_W = 8;
  localparam int FUN_W  = 4;

  localparam logic [DATA_W-1:0] CMD_OPS  = 8'hCC;
  localparam logic [DATA_W-1:0] CMD_NOP  = 8'hDD;
  localparam logic [DATA_W-1:0] ERR_CODE = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_A,
    ST_GET_B,
    ST_GET_FUN,
    ST_PRE,
    ST_EXEC,
    ST_SEND
  } state_e;

endpackage

// File: rtl/alu_cmd_ctrl.sv
// Command sequencer for the shared ALU: parses byte-serial frames from the
// RX deserializer, loads the ALU operand/function registers, enables the
// gated ALU clock only while an operation is in flight, and offers one
// result byte to the TX serializer. All outputs come straight from flops.
module alu_cmd_ctrl
  import alu_sys_pkg::*;
#(
  parameter int                DATA_W   = alu_sys_pkg::DATA_W,
  parameter int                FUN_W    = alu_sys_pkg::FUN_W,
  parameter int                ALU_LAT  = 1,
  parameter logic [DATA_W-1:0] CMD_OPS  = alu_sys_pkg::CMD_OPS,
  parameter logic [DATA_W-1:0] CMD_NOP  = alu_sys_pkg::CMD_NOP,
  parameter logic [DATA_W-1:0] ERR_CODE = alu_sys_pkg::ERR_CODE
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] RX_P_DATA,
  input  logic              RX_D_VLD,
  input  logic [DATA_W-1:0] ALU_OUT,
  input  logic              OUT_VALID,
  input  logic              TX_BUSY,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [FUN_W-1:0]  ALU_FUN,
  output logic              ALU_EN,
  output logic              CLK_GATE_EN,
  output logic [DATA_W-1:0] TX_P_DATA,
  output logic              TX_D_VLD,
  output logic              BUSY
);

  // The result is sampled on the edge where the counter reaches this value,
  // i.e. ALU_LAT cycles after ALU_EN rises.
  localparam logic [2:0] LAT_LAST = 3'(ALU_LAT - 1);

  state_e            state_q, state_d;
  logic [2:0]        latCnt_q, latCnt_d;
  logic [DATA_W-1:0] aluA_q, aluA_d;
  logic [DATA_W-1:0] aluB_q, aluB_d;
  logic [FUN_W-1:0]  aluFun_q, aluFun_d;
  logic              aluEn_q, aluEn_d;
  logic              gateEn_q, gateEn_d;
  logic [DATA_W-1:0] txData_q, txData_d;
  logic              txVld_q, txVld_d;
  logic              busy_q, busy_d;

  // State and output registers; reset aborts any frame or operation.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      latCnt_q <= '0;
      aluA_q   <= '0;
      aluB_q   <= '0;
      aluFun_q <= '0;
      aluEn_q  <= 1'b0;
      gateEn_q <= 1'b0;
      txData_q <= '0;
      txVld_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      latCnt_q <= latCnt_d;
      aluA_q   <= aluA_d;
      aluB_q   <= aluB_d;
      aluFun_q <= aluFun_d;
      aluEn_q  <= aluEn_d;
      gateEn_q <= gateEn_d;
      txData_q <= txData_d;
      txVld_q  <= txVld_d;
      busy_q   <= busy_d;
    end
  end

  // Frame parser and execution sequencer; TX strobe defaults low so it
  // can only ever last a single cycle.
  always_comb begin
    state_d  = state_q;
    latCnt_d = latCnt_q;
    aluA_d   = aluA_q;
    aluB_d   = aluB_q;
    aluFun_d = aluFun_q;
    aluEn_d  = aluEn_q;
    gateEn_d = gateEn_q;
    txData_d = txData_q;
    txVld_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_OPS) begin
            state_d = ST_GET_A;
          end else if (RX_P_DATA == CMD_NOP) begin
            state_d = ST_GET_FUN;
          end
        end
      end
      ST_GET_A: begin
        if (RX_D_VLD) begin
          aluA_d  = RX_P_DATA;
          state_d = ST_GET_B;
        end
      end
      ST_GET_B: begin
        if (RX_D_VLD) begin
          aluB_d  = RX_P_DATA;
          state_d = ST_GET_FUN;
        end
      end
      ST_GET_FUN: begin
        if (RX_D_VLD) begin
          aluFun_d = RX_P_DATA[FUN_W-1:0];
          gateEn_d = 1'b1;
          state_d  = ST_PRE;
        end
      end
      ST_PRE: begin
        aluEn_d  = 1'b1;
        latCnt_d = '0;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        latCnt_d = latCnt_q + 3'd1;
        if (latCnt_q == LAT_LAST) begin
          txData_d = OUT_VALID ? ALU_OUT : ERR_CODE;
          aluEn_d  = 1'b0;
          gateEn_d = 1'b0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!TX_BUSY) begin
          txVld_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign ALU_A       = aluA_q;
  assign ALU_B       = aluB_q;
  assign ALU_FUN     = aluFun_q;
  assign ALU_EN      = aluEn_q;
  assign CLK_GATE_EN = gateEn_q;
  assign TX_P_DATA   = txData_q;
  assign TX_D_VLD    = txVld_q;
  assign BUSY        = busy_q;

endmodule
